estagio_ex_mem: RTL and testbench



---
 rtl/estagio_ex_mem.sv | 175 +++++++++++++++++
 tb/tb_estagio_ex_mem.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/estagio_ex_mem.sv
// Execute/memory stage: operand-2 mux, ALU, data-memory load/store. Optional address check: EX_MEM_CHECK_ENDERECO_EN.
// Latency: 1 cycle for ALU ops and stores, LAT_MEM cycles for loads.
// Backpressure: outputs hold while pronto_out=0; pronto_in drops while a result is stalled or a load waits.
module estagio_ex_mem #(
  parameter int LARGURA  = 16,
  parameter int PROF_MEM = 256,
  parameter int LAT_MEM  = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               valid_in,
  output logic               pronto_in,
  input  logic               MD_Hab_Escrita,
  input  logic               MD_Leitura,
  input  logic               controleMUX_ULA,
  input  logic [7:0]         ULA_OP,
  input  logic [LARGURA-1:0] A,
  input  logic [LARGURA-1:0] B,
  input  logic [LARGURA-1:0] constanteExtendida,
  output logic               valid_out,
  input  logic               pronto_out,
  output logic [LARGURA-1:0] Saida_ULA,
  output logic [LARGURA-1:0] Saida_MemoriaDados,
  output logic               flag_zero,
  output logic               flag_carry,
  output logic               erro_endereco
);

  localparam int AW = $clog2(PROF_MEM);
  localparam int SW = $clog2(LARGURA);
  localparam int CW = (LAT_MEM > 2) ? $clog2(LAT_MEM) : 1;

  typedef enum logic {OCIOSO, ESPERA} estado_t;

  estado_t            r_estado;
  logic [CW-1:0]      r_cnt;
  logic [AW-1:0]      r_ea;
  logic               r_err;
  logic               r_z_pend;
  logic               r_c_pend;
  logic               r_valid;
  logic [LARGURA-1:0] r_ula;
  logic [LARGURA-1:0] r_md;
  logic               r_z;
  logic               r_c;
  logic               r_erro;
  logic [LARGURA-1:0] r_mem [PROF_MEM];

  logic [LARGURA-1:0] w_op2;
  logic [SW-1:0]      w_sh;
  logic [LARGURA:0]   w_add;
  logic [LARGURA:0]   w_sub;
  logic [LARGURA-1:0] w_res;
  logic               w_cy;
  logic [AW-1:0]      w_ea;
  logic               w_err;
  logic               w_acc;
  logic               w_store;
  logic               w_load;
  logic               w_mem_op;
  logic               w_long;
  logic [LARGURA-1:0] w_rd;

  assign w_op2    = controleMUX_ULA ? constanteExtendida : B;
  assign w_sh     = w_op2[SW-1:0];
  assign w_add    = {1'b0, A} + {1'b0, w_op2};
  assign w_sub    = {1'b0, A} + {1'b0, ~w_op2} + (LARGURA+1)'(1);

`ifdef EX_MEM_CHECK_ENDERECO_EN
  // Keep the carry bit so out-of-range addresses can be flagged instead of wrapped.
  logic [LARGURA:0] w_ea_full;
  assign w_ea_full = {1'b0, A} + {1'b0, constanteExtendida};
  assign w_ea      = w_ea_full[AW-1:0];
  assign w_err     = (w_ea_full >= (LARGURA+1)'(PROF_MEM));
`else
  assign w_ea  = A[AW-1:0] + constanteExtendida[AW-1:0];
  assign w_err = 1'b0;
`endif

  // A simultaneous read and write request is a store.
  assign w_store   = MD_Hab_Escrita;
  assign w_load    = MD_Leitura && !MD_Hab_Escrita;
  assign w_mem_op  = w_store || w_load;
  assign pronto_in = (r_estado == OCIOSO) && (!r_valid || pronto_out);
  assign w_acc     = valid_in && pronto_in;
  assign w_long    = w_load && (LAT_MEM > 1);
  assign w_rd      = w_err ? '0 : r_mem[w_ea];

  // ALU result and carry for the current operands
  always_comb begin
    w_res = '0;
    w_cy  = 1'b0;
    case (ULA_OP)
      8'h00: {w_cy, w_res} = w_add;
      8'h01: {w_cy, w_res} = w_sub;
      8'h02: w_res = A & w_op2;
      8'h03: w_res = A | w_op2;
      8'h04: w_res = A ^ w_op2;
      8'h05: w_res = ~A;
      8'h06: w_res = A << w_sh;
      8'h07: w_res = A >> w_sh;
      8'h08: w_res = LARGURA'($signed(A) >>> w_sh);
      8'h09: w_res = {{(LARGURA-1){1'b0}}, ($signed(A) < $signed(w_op2))};
      8'h0A: w_res = w_op2;
      default: w_res = '0;
    endcase
  end

  // Handshake FSM, result registers and memory writes; the array itself is never cleared
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_estado <= OCIOSO;
      r_cnt    <= '0;
      r_ea     <= '0;
      r_err    <= 1'b0;
      r_z_pend <= 1'b0;
      r_c_pend <= 1'b0;
      r_valid  <= 1'b0;
      r_ula    <= '0;
      r_md     <= '0;
      r_z      <= 1'b0;
      r_c      <= 1'b0;
      r_erro   <= 1'b0;
    end else begin
      case (r_estado)
        OCIOSO: begin
          if (w_acc) begin
            if (w_store && !w_err) r_mem[w_ea] <= B;
            if (w_long) begin
              // Park the address; results are registered when the wait ends.
              r_estado <= ESPERA;
              r_cnt    <= CW'(LAT_MEM - 2);
              r_ea     <= w_ea;
              r_err    <= w_err;
              r_z_pend <= (w_res == '0);
              r_c_pend <= w_cy;
              r_valid  <= 1'b0;
            end else begin
              r_valid <= 1'b1;
              r_ula   <= w_mem_op ? LARGURA'(w_ea) : w_res;
              r_md    <= w_load ? w_rd : '0;
              r_z     <= (w_res == '0);
              r_c     <= w_cy;
              r_erro  <= w_mem_op && w_err;
            end
          end else if (pronto_out) begin
            r_valid <= 1'b0;
          end
        end
        ESPERA: begin
          if (r_cnt == '0) begin
            r_estado <= OCIOSO;
            r_valid  <= 1'b1;
            r_ula    <= LARGURA'(r_ea);
            r_md     <= r_err ? '0 : r_mem[r_ea];
            r_z      <= r_z_pend;
            r_c      <= r_c_pend;
            r_erro   <= r_err;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: r_estado <= OCIOSO;
      endcase
    end
  end

  assign valid_out          = r_valid;
  assign Saida_ULA          = r_ula;
  assign Saida_MemoriaDados = r_md;
  assign flag_zero          = r_z;
  assign flag_carry         = r_c;
  assign erro_endereco      = r_erro;

endmodule

// File: tb/tb_estagio_ex_mem.sv
// Bench for estagio_ex_mem: one instance with LAT_MEM=1, one with LAT_MEM=3.
// Expected results are queued per instance when an operation is driven.
// A negedge monitor pops and compares every consumed result.
module tb_estagio_ex_mem;

`ifdef EX_MEM_CHECK_ENDERECO_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic [1:0]  vin;
  logic        pout;
  logic        wr, rd, mux;
  logic [7:0]  op;
  logic [15:0] a, b, k;
  logic        pin  [2];
  logic        vout [2];
  logic [15:0] ula  [2];
  logic [15:0] md   [2];
  logic        fz   [2];
  logic        fc   [2];
  logic        ferr [2];

  always #5 clock = ~clock;

  estagio_ex_mem #(.LARGURA(16), .PROF_MEM(256), .LAT_MEM(1)) u_lat1 (
    .clock(clock), .reset_n(reset_n), .valid_in(vin[0]), .pronto_in(pin[0]),
    .MD_Hab_Escrita(wr), .MD_Leitura(rd), .controleMUX_ULA(mux), .ULA_OP(op),
    .A(a), .B(b), .constanteExtendida(k), .valid_out(vout[0]), .pronto_out(pout),
    .Saida_ULA(ula[0]), .Saida_MemoriaDados(md[0]), .flag_zero(fz[0]),
    .flag_carry(fc[0]), .erro_endereco(ferr[0]));

  estagio_ex_mem #(.LARGURA(16), .PROF_MEM(256), .LAT_MEM(3)) u_lat3 (
    .clock(clock), .reset_n(reset_n), .valid_in(vin[1]), .pronto_in(pin[1]),
    .MD_Hab_Escrita(wr), .MD_Leitura(rd), .controleMUX_ULA(mux), .ULA_OP(op),
    .A(a), .B(b), .constanteExtendida(k), .valid_out(vout[1]), .pronto_out(pout),
    .Saida_ULA(ula[1]), .Saida_MemoriaDados(md[1]), .flag_zero(fz[1]),
    .flag_carry(fc[1]), .erro_endereco(ferr[1]));

  typedef struct {
    logic [15:0] ula;
    logic [15:0] md;
    logic        z;
    logic        c;
    logic        err;
    logic        fl;
  } sb_t;

  sb_t         q0[$];
  sb_t         q1[$];
  logic [15:0] mref [2][256];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] alu_m(input logic [7:0] o, input logic [15:0] x, input logic [15:0] y);
    logic [15:0] r;
    logic        c;
    int          sh;
    r  = 16'h0;
    c  = 1'b0;
    sh = int'(y[3:0]);
    case (o)
      8'h00: begin r = x + y; c = (int'(x) + int'(y)) > 65535; end
      8'h01: begin r = x - y; c = (x >= y); end
      8'h02: r = x & y;
      8'h03: r = x | y;
      8'h04: r = x ^ y;
      8'h05: r = ~x;
      8'h06: r = x << sh;
      8'h07: r = x >> sh;
      8'h08: r = 16'($signed(x) >>> sh);
      8'h09: r = ($signed(x) < $signed(y)) ? 16'd1 : 16'd0;
      8'h0A: r = y;
      default: r = 16'h0;
    endcase
    return {c, r};
  endfunction

  // Drive one operation into instance d, queue its expected result, wait for acceptance.
  task automatic issue(input int d, input logic s_wr, input logic s_rd, input logic s_mux,
                       input logic [7:0] s_op, input logic [15:0] s_a, input logic [15:0] s_b,
                       input logic [15:0] s_k, input bit s_push);
    sb_t         e;
    logic [16:0] r;
    logic [15:0] o2;
    int          full;
    logic [7:0]  ea;
    logic        er;
    bit          acc;
    o2    = s_mux ? s_k : s_b;
    r     = alu_m(s_op, s_a, o2);
    full  = int'(s_a) + int'(s_k);
    ea    = full[7:0];
    er    = CHK_EN && (full >= 256);
    e.ula = r[15:0];
    e.md  = 16'h0;
    e.z   = (r[15:0] == 16'h0);
    e.c   = r[16];
    e.err = 1'b0;
    e.fl  = !(s_wr || s_rd);
    if (s_wr) begin
      e.ula = {8'h00, ea};
      e.err = er;
      if (!er && s_push) mref[d][ea] = s_b;
    end else if (s_rd) begin
      e.ula = {8'h00, ea};
      e.err = er;
      e.md  = er ? 16'h0 : mref[d][ea];
    end
    {wr, rd, mux, op, a, b, k} = {s_wr, s_rd, s_mux, s_op, s_a, s_b, s_k};
    vin[d] = 1'b1;
    if (s_push) begin
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clock);
      acc = pin[d];
      @(posedge clock);
      #1;
    end
    vin[d] = 1'b0;
    chk("accept", acc, 1'b1);
  endtask

  // Count cycles from acceptance until valid_out; pronto_in must stay low meanwhile.
  task automatic check_lat(input int d, input int lat);
    int n;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      n++;
      if (vout[d]) break;
      chk("pronto_in_wait", pin[d], 1'b0);
      @(posedge clock);
      #1;
    end
    chk("load_latency", n, lat);
  endtask

  task automatic cmp(input int d, input sb_t e);
    chk(d == 0 ? "ula_l1" : "ula_l3", ula[d], e.ula);
    chk(d == 0 ? "md_l1" : "md_l3", md[d], e.md);
    chk(d == 0 ? "err_l1" : "err_l3", ferr[d], e.err);
    if (e.fl) begin
      chk(d == 0 ? "zero_l1" : "zero_l3", fz[d], e.z);
      chk(d == 0 ? "carry_l1" : "carry_l3", fc[d], e.c);
    end
  endtask

  // Scoreboard monitor: a result is consumed when valid_out and pronto_out meet at an edge.
  always @(negedge clock) begin
    if (reset_n && pout) begin
      if (vout[0]) begin
        chk("sb0_nonempty", q0.size() > 0, 1'b1);
        if (q0.size() > 0) cmp(0, q0.pop_front());
      end
      if (vout[1]) begin
        chk("sb1_nonempty", q1.size() > 0, 1'b1);
        if (q1.size() > 0) cmp(1, q1.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    vin = 2'b00; pout = 1'b1;
    {wr, rd, mux, op, a, b, k} = '0;
    #2;
    for (int d = 0; d < 2; d++) begin
      chk("rst_valid", vout[d], 1'b0);
      chk("rst_ula", ula[d], 16'h0);
      chk("rst_md", md[d], 16'h0);
      chk("rst_flags", {fz[d], fc[d], ferr[d]}, 3'b000);
      chk("rst_pronto_in", pin[d], 1'b1);
    end
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    chk("pronto_after_rst", {pin[0], pin[1]}, 2'b11);
    @(posedge clock); #1;

    // ALU: ADD wraps to zero with carry, checked one cycle after acceptance
    issue(0, 0, 0, 1, 8'h00, 16'hFFFF, 16'h0000, 16'h0001, 1);
    chk("add_valid", vout[0], 1'b1);
    chk("add_res", ula[0], 16'h0000);
    chk("add_zc", {fz[0], fc[0]}, 2'b11);
    // Back-to-back ALU stream exercising every operation code
    issue(0, 0, 0, 0, 8'h01, 16'h0005, 16'h0007, 16'h0000, 1);
    issue(0, 0, 0, 0, 8'h01, 16'h0007, 16'h0005, 16'h0000, 1);
    issue(0, 0, 0, 0, 8'h02, 16'hF0F0, 16'h3C3C, 16'h0000, 1);
    issue(0, 0, 0, 0, 8'h03, 16'hF0F0, 16'h0F01, 16'h0000, 1);
    issue(0, 0, 0, 1, 8'h04, 16'hAAAA, 16'h0000, 16'hFFFF, 1);
    issue(0, 0, 0, 0, 8'h05, 16'h1234, 16'h0000, 16'h0000, 1);
    issue(0, 0, 0, 1, 8'h06, 16'h0003, 16'h0000, 16'h0014, 1);
    issue(0, 0, 0, 0, 8'h07, 16'h8000, 16'h000F, 16'h0000, 1);
    issue(0, 0, 0, 0, 8'h08, 16'h8000, 16'h0004, 16'h0000, 1);
    issue(0, 0, 0, 0, 8'h09, 16'h8000, 16'h0001, 16'h0000, 1);
    chk("slt_res", ula[0], 16'h0001);
    issue(0, 0, 0, 1, 8'h0A, 16'h1111, 16'h2222, 16'h3333, 1);
    issue(0, 0, 0, 0, 8'h3C, 16'h1234, 16'h5678, 16'h0000, 1);
    repeat (2) @(posedge clock); #1;

    // Store then load at A+const=0x12 on both latencies
    for (int d = 0; d < 2; d++) begin
      issue(d, 1, 0, 0, 8'h00, 16'h0010, 16'hBEEF, 16'h0002, 1);
      issue(d, 0, 1, 0, 8'h00, 16'h0010, 16'h0000, 16'h0002, 1);
      check_lat(d, d == 0 ? 1 : 3);
      chk("load_ea", ula[d], 16'h0012);
      chk("load_data", md[d], 16'hBEEF);
      repeat (2) @(posedge clock); #1;
    end
    // Read and write together behave as a store
    issue(0, 1, 1, 0, 8'h00, 16'h0030, 16'h7777, 16'h0000, 1);
    chk("wr_rd_md", md[0], 16'h0000);
    issue(0, 0, 1, 0, 8'h00, 16'h0030, 16'h0000, 16'h0000, 1);
    repeat (2) @(posedge clock); #1;

    // Backpressure: result held, next op waits, then three results drain in order
    pout = 1'b0;
    issue(0, 0, 0, 0, 8'h00, 16'h0100, 16'h0023, 16'h0000, 1);
    {op, a, b} = {8'h04, 16'h00FF, 16'h0F0F};
    vin[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("bp_pronto_in", pin[0], 1'b0);
      chk("bp_valid", vout[0], 1'b1);
      chk("bp_hold", ula[0], 16'h0123);
      @(posedge clock); #1;
    end
    pout = 1'b1;
    issue(0, 0, 0, 0, 8'h04, 16'h00FF, 16'h0F0F, 16'h0000, 1);
    issue(0, 0, 0, 0, 8'h01, 16'h0000, 16'h0001, 16'h0000, 1);
    repeat (2) @(posedge clock); #1;

    // Address range: 0xFF+2 wraps to 1 or is flagged as an error
    issue(0, 1, 0, 0, 8'h00, 16'h0001, 16'h5555, 16'h0000, 1);
    issue(0, 1, 0, 0, 8'h00, 16'h00FF, 16'h1234, 16'h0002, 1);
    chk("range_err", ferr[0], CHK_EN);
    issue(0, 0, 1, 0, 8'h00, 16'h0001, 16'h0000, 16'h0000, 1);
    chk("range_mem1", md[0], CHK_EN ? 16'h5555 : 16'h1234);
    repeat (2) @(posedge clock); #1;

    // Reset during a LAT_MEM=3 load, with a store presented while reset is low
    issue(1, 1, 0, 0, 8'h00, 16'h0020, 16'h1111, 16'h0000, 1);
    @(posedge clock); #1;
    issue(1, 0, 1, 0, 8'h00, 16'h0020, 16'h0000, 16'h0000, 0);
    {wr, rd, a, b, k} = {1'b1, 1'b0, 16'h0020, 16'hDEAD, 16'h0000};
    vin[1] = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", vout[1], 1'b0);
    chk("midrst_outs", {ula[1], md[1]}, 32'h0);
    chk("midrst_flags", {fz[1], fc[1], ferr[1]}, 3'b000);
    chk("midrst_pronto_in", pin[1], 1'b1);
    repeat (2) @(posedge clock);
    #1;
    vin[1] = 1'b0;
    wr = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("no_valid_after_rst", vout[1], 1'b0);
    end
    @(posedge clock); #1;
    issue(1, 0, 1, 0, 8'h00, 16'h0020, 16'h0000, 16'h0000, 1);
    check_lat(1, 3);
    chk("mem_kept", md[1], 16'h1111);

    repeat (4) @(posedge clock); #1;
    chk("sb0_drained", q0.size(), 0);
    chk("sb1_drained", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
